uart_tx_serializer: RTL and testbench

Serial UART transmitter and bit-level back end for the UART controller's TX path. It accepts a byte plus a start request from the controller and acknowledges it with a one-cycle start-clear pulse. It then shifts out a start bit, the data bits (LSB first), an optional parity bit and the stop bit(s) on the tx line, reporting busy for the whole frame. It sits between the controller's tx data/start outputs and the chip pad.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_tx_serializer.sv | 150 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and parity
// sense constants used by both the TX and RX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   DEFAULT_CLKS_PER_BIT = 434;
    localparam logic LINE_IDLE            = 1'b1;

    localparam logic PARITY_SENSE_EVEN = 1'b0;
    localparam logic PARITY_SENSE_ODD  = 1'b1;

    // Parity bit that makes the total count of ones even (sense=0) or odd (sense=1).
    function automatic logic parity_of(input logic [7:0] data, input logic sense);
        return (^data) ^ sense;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit period. Held at zero while disabled.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit back end: latches a byte on request and shifts out start,
// data (LSB first), optional parity and stop bits on a registered line.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_start,
    output logic       o_tx_start_clear,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_tx,
    output tx_state_t  dbg_state
);

    localparam logic [7:0] DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       SENSE     = (PARITY_ODD != 0) ? PARITY_SENSE_ODD : PARITY_SENSE_EVEN;

    // Handshake: i_tx_start is a level request the controller holds until it
    // sees o_tx_start_clear. The request is only sampled in IDLE; the clear
    // pulse lasts one cycle and coincides with the first cycle of the start bit.
    tx_state_t  state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic       parity_q, parity_d;
    logic       tx_q, tx_d;
    logic       clear_q, clear_d;
    logic       done_q, done_d;
    logic       tick;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= LINE_IDLE;
            clear_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            clear_q    <= clear_d;
            done_q     <= done_d;
        end
    end

    // The line is registered, so each branch loads the level of the bit that
    // starts on the next cycle.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        clear_d    = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = LINE_IDLE;
                if (i_tx_start) begin
                    shreg_d    = i_tx_data & DATA_MASK;
                    parity_d   = parity_of(i_tx_data & DATA_MASK, SENSE);
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    clear_d    = 1'b1;
                    tx_d       = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = LINE_IDLE;
                            state_d = STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        tx_d      = shreg_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    tx_d    = LINE_IDLE;
                    state_d = STOP;
                end
            end
            STOP: begin
                tx_d = LINE_IDLE;
                if (tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = LINE_IDLE;
                state_d = IDLE;
            end
        endcase
    end

    assign o_tx             = tx_q;
    assign o_tx_busy        = (state_q != IDLE);
    assign o_tx_start_clear = clear_q;
    assign o_tx_done        = done_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: several parameter sets run side by side, each
// with a random-byte driver, an expected-byte queue and a line-decoding monitor.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int NCFG    = 6;
    localparam int NFRAMES = 12;
    localparam int CPB_A [NCFG] = '{4, 4, 4, 3, 2, 5};
    localparam int DB_A  [NCFG] = '{8, 8, 8, 7, 5, 6};
    localparam int PE_A  [NCFG] = '{0, 1, 1, 0, 1, 1};
    localparam int PO_A  [NCFG] = '{0, 0, 1, 0, 1, 0};
    localparam int SB_A  [NCFG] = '{1, 1, 1, 2, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    wire [NCFG-1:0] all_done;

    task automatic check(input string name, input int cfg, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cfg%0d: got %0h expected %0h at %0t", name, cfg, got, exp, $time);
        end
    endtask

    for (genvar k = 0; k < NCFG; k++) begin : g_cfg
        localparam int C = CPB_A[k];
        localparam int D = DB_A[k];
        localparam int P = PE_A[k];
        localparam int PO = PO_A[k];
        localparam int S = SB_A[k];
        localparam int NBITS = 1 + D + P + S;
        localparam int L = NBITS * C;
        localparam logic [7:0] MASK = 8'((16'd1 << D) - 16'd1);

        logic       rst_n;
        logic       start;
        logic [7:0] data;
        logic       clear, busy, done, tx;
        tx_state_t  st;
        logic [7:0] exp_q [$];
        bit         fin = 1'b0;

        assign all_done[k] = fin;

        uart_tx_serializer #(
            .CLKS_PER_BIT(C),
            .DATA_BITS   (D),
            .PARITY_EN   (P),
            .PARITY_ODD  (PO),
            .STOP_BITS   (S)
        ) dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .i_tx_data       (data),
            .i_tx_start      (start),
            .o_tx_start_clear(clear),
            .o_tx_busy       (busy),
            .o_tx_done       (done),
            .o_tx            (tx),
            .dbg_state       (st)
        );

        // Driver: random bytes, optional back-to-back hold, ignored mid-frame requests.
        initial begin
            logic [7:0] b;
            bit hold, seen, bad;
            int w;
            rst_n = 1'b0;
            start = 1'b0;
            data  = 8'h00;
            repeat (3) @(negedge clk);
            check("reset_out", k, {28'd0, tx, busy, clear, done}, 32'h8);
            check("reset_state", k, 32'(st), 32'(IDLE));
            #2 rst_n = 1'b1;
            b = 8'($urandom);
            data = b;
            start = 1'b1;
            exp_q.push_back(b);
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (clear) begin seen = 1'b1; break; end
            end
            check("clear_seen", k, 32'(seen), 32'd1);
            for (int f = 0; f < NFRAMES; f++) begin
                hold = (f < NFRAMES - 1) && ($urandom_range(0, 1) == 1);
                if (!hold) start = 1'b0;
                w = $urandom_range(1, L - 4);
                repeat (w) @(negedge clk);
                data = 8'($urandom);
                if (!hold) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                seen = 1'b0;
                for (int i = 0; i < L + 4; i++) begin
                    @(negedge clk);
                    if (done) begin seen = 1'b1; break; end
                end
                check("done_seen", k, 32'(seen), 32'd1);
                if (f < NFRAMES - 1) begin
                    b = 8'($urandom);
                    data = b;
                    exp_q.push_back(b);
                    if (hold) begin
                        @(negedge clk);
                        check("b2b_gap", k, 32'(clear), 32'd1);
                    end else begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        start = 1'b1;
                        seen = 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            @(negedge clk);
                            if (clear) begin seen = 1'b1; break; end
                        end
                        check("clear_seen", k, 32'(seen), 32'd1);
                    end
                end
            end
            repeat (2) @(negedge clk);
            check("queue_drained", k, 32'(exp_q.size()), 32'd0);

            // Reset in the middle of data bit 3.
            b = 8'($urandom);
            data = b;
            exp_q.push_back(b);
            start = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (clear) begin seen = 1'b1; break; end
            end
            check("clear_seen", k, 32'(seen), 32'd1);
            start = 1'b0;
            repeat (4 * C + 1) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("async_reset", k, {28'd0, tx, busy, clear, done}, 32'h8);
            check("async_reset_state", k, 32'(st), 32'(IDLE));
            repeat (2) @(negedge clk);
            #2 rst_n = 1'b1;
            bad = 1'b0;
            repeat (3 * L) begin
                @(negedge clk);
                if (!tx || busy || done || clear) bad = 1'b1;
            end
            check("post_reset_idle", k, 32'(bad), 32'd0);
            check("queue_after_reset", k, 32'(exp_q.size()), 32'd0);
            fin = 1'b1;
        end

        // Monitor: decodes each frame from the line and checks it against the queue.
        initial begin
            logic       prev_tx;
            logic       s_tx [L];
            bit         aborted, busy_ok, clr_ok, done_ok, stable_ok;
            logic [7:0] eb, exp_data, got_data;
            logic [15:0] exp_frame, got_frame;
            int         idx;
            prev_tx = 1'b1;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    prev_tx = 1'b1;
                    continue;
                end
                if (prev_tx && !tx) begin
                    aborted = 1'b0;
                    busy_ok = 1'b1;
                    clr_ok  = 1'b1;
                    done_ok = 1'b1;
                    for (int i = 0; i < L; i++) begin
                        if (i > 0) @(negedge clk);
                        if (!rst_n) begin aborted = 1'b1; break; end
                        s_tx[i] = tx;
                        if (!busy) busy_ok = 1'b0;
                        if (clear !== (i == 0)) clr_ok = 1'b0;
                        if (done) done_ok = 1'b0;
                    end
                    if (aborted) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        prev_tx = 1'b1;
                        continue;
                    end
                    @(negedge clk);
                    check("frame_end", k, {29'd0, done, busy, tx}, 32'h5);
                    check("busy_in_frame", k, 32'(busy_ok), 32'd1);
                    check("clear_once", k, 32'(clr_ok), 32'd1);
                    check("no_early_done", k, 32'(done_ok), 32'd1);
                    stable_ok = 1'b1;
                    got_frame = '0;
                    for (int j = 0; j < NBITS; j++) begin
                        got_frame[j] = s_tx[j * C];
                        for (int c = 1; c < C; c++)
                            if (s_tx[j * C + c] !== s_tx[j * C]) stable_ok = 1'b0;
                    end
                    check("bit_stable", k, 32'(stable_ok), 32'd1);
                    check("queue_nonempty", k, 32'(exp_q.size() > 0), 32'd1);
                    eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                    exp_data = eb & MASK;
                    got_data = '0;
                    for (int i = 0; i < D; i++) got_data[i] = s_tx[(1 + i) * C];
                    check("data", k, 32'(got_data), 32'(exp_data));
                    exp_frame = '0;
                    idx = 1;
                    for (int i = 0; i < D; i++) begin
                        exp_frame[idx] = exp_data[i];
                        idx++;
                    end
                    if (P != 0) begin
                        exp_frame[idx] = 1'(($countones(exp_data) + PO) % 2);
                        idx++;
                    end
                    for (int s = 0; s < S; s++) begin
                        exp_frame[idx] = 1'b1;
                        idx++;
                    end
                    check("frame_bits", k, 32'(got_frame), 32'(exp_frame));
                    prev_tx = tx;
                end else begin
                    prev_tx = tx;
                end
            end
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (all_done != {NCFG{1'b1}} && cyc < 40000) begin
            @(negedge clk);
            cyc++;
        end
        check("all_finished", 0, 32'(all_done), 32'((1 << NCFG) - 1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
